// File: rtl/cpu_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_bridge_if
//   CPU-side four-phase request/acknowledge bus between the cpu core (master)
//   and cpu_bus_bridge (slave). Signal names follow the bridge's point of view.
//
//   i_bus_clk         cpu -> bridge  request strobe (level, high = request)
//   i_bus_we          cpu -> bridge  1 = write
//   i_bus_addr        cpu -> bridge  address
//   i_bus_data        cpu -> bridge  write data
//   o_bus_data        bridge -> cpu  read data (holds last read)
//   o_bus_data_ready  bridge -> cpu  transaction complete
// -----------------------------------------------------------------------------
interface cpu_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_bus_clk;
  logic              i_bus_we;
  logic [ADDR_W-1:0] i_bus_addr;
  logic [DATA_W-1:0] i_bus_data;
  logic [DATA_W-1:0] o_bus_data;
  logic              o_bus_data_ready;

  // cpu side
  modport master (
    output i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
    input  o_bus_data, o_bus_data_ready
  );

  // bridge side
  modport slave (
    input  i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
    output o_bus_data, o_bus_data_ready
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// -----------------------------------------------------------------------------
// cpu_bus_bridge
//   Accepts one four-phase cpu request at a time and routes it either to the
//   memory port (req held until a single-cycle ack) or to the 8-bit I/O
//   register window (fixed IO_WAIT+1 cycle select). Read data and the
//   completion flag go back to the cpu over the bus interface.
//
//   Optional feature macro: CPU_BUS_TIMEOUT_EN
//     defined   : a memory access without ack for TIMEOUT_CYCLES cycles is
//                 abandoned, reads return all-ones, sticky o_bus_err is set.
//     undefined : memory waits indefinitely, o_bus_err is tied low.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   bus               cpu_bus_bridge_if.slave (cpu request / response)
//   o_mem_req/we/addr/wdata, i_mem_rdata, i_mem_ack   memory port
//   o_io_sel/we/addr/wdata, i_io_rdata                I/O register port
//   o_bus_err         sticky timeout error
// -----------------------------------------------------------------------------
module cpu_bus_bridge #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] IO_BASE        = 32'h0000_FF00,
  parameter logic [ADDR_W-1:0] IO_MASK        = 32'hFFFF_FF00,
  parameter int                IO_WAIT        = 2,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cpu_bus_bridge_if.slave   bus,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_io_sel,
  output logic              o_io_we,
  output logic [7:0]        o_io_addr,
  output logic [7:0]        o_io_wdata,
  input  logic [7:0]        i_io_rdata,
  output logic              o_bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_IO   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic [3:0] IO_WAIT_L = 4'(IO_WAIT);

  state_t            state_r;
  logic              we_r;
  logic [3:0]        wait_cnt_r;
  logic [DATA_W-1:0] bus_data_r;
  logic              ready_r;
  logic              io_hit_s;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_r;
`else
  assign o_bus_err = 1'b0;
`endif

  assign io_hit_s             = ((bus.i_bus_addr & IO_MASK) == IO_BASE);
  assign bus.o_bus_data       = bus_data_r;
  assign bus.o_bus_data_ready = ready_r;

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      wait_cnt_r  <= 4'd0;
      bus_data_r  <= {DATA_W{1'b0}};
      ready_r     <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= {ADDR_W{1'b0}};
      o_mem_wdata <= {DATA_W{1'b0}};
      o_io_sel    <= 1'b0;
      o_io_we     <= 1'b0;
      o_io_addr   <= 8'd0;
      o_io_wdata  <= 8'd0;
`ifdef CPU_BUS_TIMEOUT_EN
      tmo_cnt_r   <= {TMO_W{1'b0}};
      o_bus_err   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_bus_clk) begin
            we_r <= bus.i_bus_we;
            if (io_hit_s) begin
              state_r    <= ST_IO;
              o_io_sel   <= 1'b1;
              o_io_addr  <= bus.i_bus_addr[7:0];
              o_io_wdata <= bus.i_bus_data[7:0];
              // With no wait states the first select cycle is also the last.
              o_io_we    <= bus.i_bus_we && (IO_WAIT_L == 4'd0);
              wait_cnt_r <= 4'd0;
            end else begin
              state_r     <= ST_MEM;
              o_mem_req   <= 1'b1;
              o_mem_we    <= bus.i_bus_we;
              o_mem_addr  <= bus.i_bus_addr;
              o_mem_wdata <= bus.i_bus_data;
`ifdef CPU_BUS_TIMEOUT_EN
              tmo_cnt_r   <= {TMO_W{1'b0}};
`endif
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_MEM: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            if (!we_r) begin
              bus_data_r <= i_mem_rdata;
            end else begin
              bus_data_r <= bus_data_r;
            end
            ready_r <= 1'b1;
            state_r <= ST_ACK;
          end
`ifdef CPU_BUS_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            // Ack never came: abandon the access and flag it permanently.
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            if (!we_r) begin
              bus_data_r <= {DATA_W{1'b1}};
            end else begin
              bus_data_r <= bus_data_r;
            end
            o_bus_err <= 1'b1;
            ready_r   <= 1'b1;
            state_r   <= ST_ACK;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
`else
          else begin
            state_r <= ST_MEM;
          end
`endif
        end

        ST_IO: begin
          if (wait_cnt_r == IO_WAIT_L) begin
            o_io_sel <= 1'b0;
            o_io_we  <= 1'b0;
            if (!we_r) begin
              bus_data_r <= {{(DATA_W-8){1'b0}}, i_io_rdata};
            end else begin
              bus_data_r <= bus_data_r;
            end
            ready_r <= 1'b1;
            state_r <= ST_ACK;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
            // Write strobe rises one edge ahead so it covers the final cycle.
            o_io_we    <= we_r && ((wait_cnt_r + 4'd1) == IO_WAIT_L);
          end
        end

        ST_ACK: begin
          // Four-phase completion: hold ready until the cpu withdraws.
          if (!bus.i_bus_clk) begin
            ready_r <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            ready_r <= 1'b1;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          ready_r   <= 1'b0;
          o_mem_req <= 1'b0;
          o_mem_we  <= 1'b0;
          o_io_sel  <= 1'b0;
          o_io_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
